// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with watermark flags, fill level, sticky error flags and flush.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; otherwise data_out is a registered read.
module sync_fifo_param #(
    parameter int DATA_WIDTH    = 8,
    parameter int PTR_WIDTH     = 3,
    parameter int DEPTH         = 8,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  clr_err,
    input  logic                  w_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  r_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    fill_level,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0] PTR_ONE   = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0] AFULL_T   = AFULL_THRESH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AEMPTY_T  = AEMPTY_THRESH[PTR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [PTR_WIDTH:0] wptr_q, wptr_d;
    logic [PTR_WIDTH:0] rptr_q, rptr_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;
    logic               wr_acc, rd_acc;

    // Status is derived purely from the registered pointers, so flags track accepted ops with no lag.
    assign full         = (wptr_q[PTR_WIDTH] != rptr_q[PTR_WIDTH]) &&
                          (wptr_q[PTR_WIDTH-1:0] == rptr_q[PTR_WIDTH-1:0]);
    assign empty        = (wptr_q == rptr_q);
    assign fill_level   = wptr_q - rptr_q;
    assign almost_full  = (fill_level >= AFULL_T);
    assign almost_empty = (fill_level <= AEMPTY_T);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    assign wr_acc = w_en && !full  && !flush;
    assign rd_acc = r_en && !empty && !flush;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = overflow_q  && !clr_err;
        underflow_d = underflow_q && !clr_err;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (wr_acc) wptr_d = wptr_q + PTR_ONE;
            if (rd_acc) rptr_d = rptr_q + PTR_ONE;
            // A fresh error wins over a same-cycle clear.
            if (w_en && full)  overflow_d  = 1'b1;
            if (r_en && empty) underflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[wptr_q[PTR_WIDTH-1:0]] <= data_in;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign data_out = mem[rptr_q[PTR_WIDTH-1:0]];
`else
    logic [DATA_WIDTH-1:0] data_out_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out_q <= '0;
        end else if (rd_acc) begin
            data_out_q <= mem[rptr_q[PTR_WIDTH-1:0]];
        end
    end

    assign data_out = data_out_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed self-checking bench for sync_fifo_param (8x8, thresholds 6/2).
module tb_sync_fifo_param;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       clr_err = 1'b0;
    logic       w_en = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       r_en = 1'b0;
    logic [7:0] data_out;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] fill_level;

    int errors = 0;
    int checks = 0;

    sync_fifo_param #(
        .DATA_WIDTH(8), .PTR_WIDTH(3), .DEPTH(8), .AFULL_THRESH(6), .AEMPTY_THRESH(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .clr_err(clr_err),
        .w_en(w_en), .data_in(data_in), .r_en(r_en), .data_out(data_out),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .fill_level(fill_level), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] d);
        w_en = 1'b1; data_in = d;
        tick();
        w_en = 1'b0;
    endtask

    task automatic do_read();
        r_en = 1'b1;
        tick();
        r_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", empty); end
        checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", full); end
        checks++; if (fill_level !== 4'd0) begin errors++; $display("FAIL reset_fill: got %0d expected 0", fill_level); end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_almost: got ae=%b af=%b expected ae=1 af=0", almost_empty, almost_full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_err: got ov=%b un=%b expected 0 0", overflow, underflow); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h expected 00", data_out); end
`endif
        $display("reset: fill=%0d empty=%b", fill_level, empty);
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            do_write(8'h11 + 8'(i));
            checks++; if (fill_level !== 4'(i + 1)) begin errors++; $display("FAIL fill_level[%0d]: got %0d expected %0d", i, fill_level, i + 1); end
            checks++; if (almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_afull[%0d]: got %b expected %b", i, almost_full, (i + 1 >= 6)); end
            checks++; if (full !== (i == 7)) begin errors++; $display("FAIL fill_full[%0d]: got %b expected %b", i, full, (i == 7)); end
            $display("write %h: fill=%0d af=%b full=%b", 8'h11 + 8'(i), fill_level, almost_full, full);
        end
        do_write(8'h99);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b expected 1", overflow); end
        checks++; if (fill_level !== 4'd8) begin errors++; $display("FAIL overflow_fill: got %0d expected 8", fill_level); end
        $display("write 99 while full: ov=%b fill=%0d", overflow, fill_level);
    endtask

    task automatic test_drain();
        for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            checks++; if (data_out !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_head[%0d]: got %h expected %h", i, data_out, 8'h11 + 8'(i)); end
`endif
            do_read();
`ifndef SYNC_FIFO_FWFT_EN
            checks++; if (data_out !== 8'h11 + 8'(i)) begin errors++; $display("FAIL drain_data[%0d]: got %h expected %h", i, data_out, 8'h11 + 8'(i)); end
`endif
            checks++; if (fill_level !== 4'(7 - i)) begin errors++; $display("FAIL drain_fill[%0d]: got %0d expected %0d", i, fill_level, 7 - i); end
            checks++; if (almost_empty !== (7 - i <= 2)) begin errors++; $display("FAIL drain_aempty[%0d]: got %b expected %b", i, almost_empty, (7 - i <= 2)); end
            checks++; if (empty !== (i == 7)) begin errors++; $display("FAIL drain_empty[%0d]: got %b expected %b", i, empty, (i == 7)); end
            $display("read: dout=%h fill=%0d ae=%b empty=%b", data_out, fill_level, almost_empty, empty);
        end
        do_read();
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %b expected 1", underflow); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL clr_err: got ov=%b un=%b expected 0 0", overflow, underflow); end
        $display("clr_err: ov=%b un=%b", overflow, underflow);
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) do_write(8'h21 + 8'(i));
        for (int i = 0; i < 3; i++) begin
            do_read();
`ifndef SYNC_FIFO_FWFT_EN
            checks++; if (data_out !== 8'h21 + 8'(i)) begin errors++; $display("FAIL wrap_rd1[%0d]: got %h expected %h", i, data_out, 8'h21 + 8'(i)); end
`endif
        end
        for (int i = 0; i < 6; i++) do_write(8'h26 + 8'(i));
        checks++; if (full !== 1'b1 || fill_level !== 4'd8) begin errors++; $display("FAIL wrap_full: got full=%b fill=%0d expected 1 8", full, fill_level); end
        for (int i = 0; i < 8; i++) begin
`ifdef SYNC_FIFO_FWFT_EN
            checks++; if (data_out !== 8'h24 + 8'(i)) begin errors++; $display("FAIL wrap_head[%0d]: got %h expected %h", i, data_out, 8'h24 + 8'(i)); end
`endif
            do_read();
`ifndef SYNC_FIFO_FWFT_EN
            checks++; if (data_out !== 8'h24 + 8'(i)) begin errors++; $display("FAIL wrap_rd2[%0d]: got %h expected %h", i, data_out, 8'h24 + 8'(i)); end
`endif
            $display("wrap read: dout=%h fill=%0d", data_out, fill_level);
        end
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty: got %b expected 1", empty); end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) do_write(8'h30 + 8'(i));
        w_en = 1'b1; r_en = 1'b1; data_in = 8'hEE;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        checks++; if (fill_level !== 4'd7 || overflow !== 1'b1) begin errors++; $display("FAIL sim_full: got fill=%0d ov=%b expected 7 1", fill_level, overflow); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (data_out !== 8'h30) begin errors++; $display("FAIL sim_full_dout: got %h expected 30", data_out); end
`endif
        $display("both on full: fill=%0d ov=%b dout=%h", fill_level, overflow, data_out);
        for (int i = 0; i < 7; i++) do_read();
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (data_out !== 8'h37) begin errors++; $display("FAIL sim_last: got %h expected 37", data_out); end
`endif
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        w_en = 1'b1; r_en = 1'b1; data_in = 8'hAB;
        tick();
        w_en = 1'b0; r_en = 1'b0;
        checks++; if (fill_level !== 4'd1 || underflow !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL sim_empty: got fill=%0d un=%b ov=%b expected 1 1 0", fill_level, underflow, overflow); end
`ifdef SYNC_FIFO_FWFT_EN
        checks++; if (data_out !== 8'hAB) begin errors++; $display("FAIL sim_ab_head: got %h expected ab", data_out); end
`endif
        do_read();
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (data_out !== 8'hAB) begin errors++; $display("FAIL sim_ab_read: got %h expected ab", data_out); end
`endif
        checks++; if (empty !== 1'b1) begin errors++; $display("FAIL sim_ab_empty: got %b expected 1", empty); end
        $display("both on empty then read: dout=%h empty=%b", data_out, empty);
    endtask

    task automatic test_flush_clear();
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        for (int i = 0; i < 4; i++) do_write(8'h41 + 8'(i));
        flush = 1'b1; w_en = 1'b1; data_in = 8'h55;
        tick();
        flush = 1'b0; w_en = 1'b0;
        checks++; if (empty !== 1'b1 || fill_level !== 4'd0) begin errors++; $display("FAIL flush_empty: got empty=%b fill=%0d expected 1 0", empty, fill_level); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL flush_noerr: got ov=%b un=%b expected 0 0", overflow, underflow); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (data_out !== 8'hAB) begin errors++; $display("FAIL flush_dout_hold: got %h expected ab", data_out); end
`endif
        $display("flush+write: empty=%b fill=%0d", empty, fill_level);
        do_read();
        checks++; if (underflow !== 1'b1 || empty !== 1'b1) begin errors++; $display("FAIL flush_dropped: got un=%b empty=%b expected 1 1", underflow, empty); end
        flush = 1'b1; tick(); flush = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL flush_sticky: got %b expected 1", underflow); end
        clr_err = 1'b1; r_en = 1'b1; tick(); clr_err = 1'b0; r_en = 1'b0;
        checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL clr_vs_new: got %b expected 1", underflow); end
        clr_err = 1'b1; tick(); clr_err = 1'b0;
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clr_only: got %b expected 0", underflow); end
        $display("clear: un=%b", underflow);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) do_write(8'h61 + 8'(i));
        do_read();
        for (int i = 0; i < 8; i++) do_write(8'h71 + 8'(i));
        rst_n = 1'b0; w_en = 1'b1; data_in = 8'h7F;
        tick();
        rst_n = 1'b1; w_en = 1'b0;
        checks++; if (empty !== 1'b1 || full !== 1'b0 || fill_level !== 4'd0) begin errors++; $display("FAIL rstmid_ptr: got empty=%b full=%b fill=%0d expected 1 0 0", empty, full, fill_level); end
        checks++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin errors++; $display("FAIL rstmid_almost: got ae=%b af=%b expected 1 0", almost_empty, almost_full); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL rstmid_err: got ov=%b un=%b expected 0 0", overflow, underflow); end
`ifndef SYNC_FIFO_FWFT_EN
        checks++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_dout: got %h expected 00", data_out); end
`endif
        $display("reset mid-stream: fill=%0d empty=%b", fill_level, empty);
    endtask

`ifdef SYNC_FIFO_FWFT_EN
    task automatic test_fwft();
        do_write(8'h5A);
        checks++; if (data_out !== 8'h5A) begin errors++; $display("FAIL fwft_head: got %h expected 5a", data_out); end
        do_write(8'h5B);
        do_read();
        checks++; if (data_out !== 8'h5B) begin errors++; $display("FAIL fwft_pop: got %h expected 5b", data_out); end
        $display("fwft: dout=%h fill=%0d", data_out, fill_level);
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_flush_clear();
        test_reset_mid();
`ifdef SYNC_FIFO_FWFT_EN
        test_fwft();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO with depth, width and watermark thresholds set by parameters. It adds almost-full/almost-empty flags, a fill-level count, sticky overflow/underflow error flags and a synchronous flush. An optional first-word-fall-through read mode is selected at compile time. It is the single-clock buffer for same-domain datapaths, next to the dual-clock FIFO.

## Interface
- `DATA_WIDTH`, 8, word width in bits.
- `PTR_WIDTH`, 3, address width. Depth is 2**PTR_WIDTH.
- `DEPTH`, 8, number of storage words. Must equal 2**PTR_WIDTH; other values are unsupported.
- `AFULL_THRESH`, 6, almost_full asserts when fill_level >= this value. Legal range 1..DEPTH.
- `AEMPTY_THRESH`, 2, almost_empty asserts when fill_level <= this value. Legal range 0..DEPTH-1.

- `clk`  in  1  the single clock; all state changes on its rising edge.
- `rst_n`  in  1  synchronous reset, active-low. Sampled on the rising edge of `clk`.
- `flush`  in  1  synchronous empty request.
- `clr_err`  in  1  clears the sticky error flags.
- `w_en`  in  1  write request.
- `data_in`  in  DATA_WIDTH  write data.
- `r_en`  in  1  read request (in FWFT mode, a pop).
- `data_out`  out  DATA_WIDTH  read data.
- `full`  out  1  fill_level == DEPTH.
- `empty`  out  1  fill_level == 0.
- `almost_full`  out  1  watermark flag, see `AFULL_THRESH`.
- `almost_empty`  out  1  watermark flag, see `AEMPTY_THRESH`.
- `fill_level`  out  PTR_WIDTH+1  number of stored words, 0..DEPTH.
- `overflow`  out  1  sticky; set by a write request while full.
- `underflow`  out  1  sticky; set by a read request while empty.

## Operation
- **Pointers.** Binary `wptr` and `rptr`, each PTR_WIDTH+1 bits.
  - Memory is addressed by the low PTR_WIDTH bits.
  - The MSB is the wrap bit.
  - Both pointers increment modulo 2**(PTR_WIDTH+1).
- **Derived outputs.** All computed from the registered pointers:
  - `full`: MSBs differ and the low bits are equal.
  - `empty`: pointers are equal.
  - `fill_level` = wptr − rptr, taken modulo 2**(PTR_WIDTH+1).
- **Write.** When `w_en` is high and `full` is low, `data_in` is stored at mem[wptr] and wptr increments.
  - If `w_en` is high and `full` is high: no store, no pointer change, `overflow` is set.
- **Read.** When `r_en` is high and `empty` is low, rptr increments.
  - If `r_en` is high and `empty` is high: no pointer change, `underflow` is set.
- **Simultaneous read and write.** Each is qualified against the flags as they stand at the start of the cycle.
  - Full with both requests: the read is accepted, the write is rejected, `overflow` is set, fill_level becomes DEPTH−1.
  - Empty with both requests: the write is accepted, the read is rejected, `underflow` is set, fill_level becomes 1.
  - Otherwise both are accepted and fill_level is unchanged.
- **Flush.** wptr and rptr go to 0, so the FIFO becomes empty.
  - Memory contents are not cleared.
  - `w_en` and `r_en` in the same cycle are ignored and raise no errors.
  - `data_out` holds its value.
  - Sticky flags are unaffected.
- **Error clear.** `clr_err` clears `overflow` and `underflow`. A new error in the same cycle takes precedence, so the flag stays set.
- **Priority:** `rst_n` low > `flush` > normal read/write.
- **Reset values:** pointers 0, `data_out` 0, `overflow`/`underflow` 0.
  - This gives `empty`=1, `full`=0, `fill_level`=0, `almost_empty`=1, `almost_full`=0.
  - Memory is not reset.
  - Reset asserted mid-stream discards all stored words at that edge.

## Timing
- **Flag update.** A write or read accepted at edge N changes `full`, `empty`, `almost_*` and `fill_level` immediately after edge N. There are no extra flag pipeline stages.
- **Standard mode read.**
  - `data_out` is registered and loads mem[rptr] at the edge where the read is accepted.
  - Read latency is 1 cycle.
  - `data_out` holds its value when no read is accepted.
- **Write-to-read.** A word written at edge N can be read-accepted at edge N+1. With no bypass, minimum write-to-`data_out` latency is 2 edges.
- **Error flags** rise at the edge of the offending request.

## Configuration
- **`SYNC_FIFO_FWFT_EN` defined: first-word-fall-through mode.**
  - `data_out` = mem[rptr] combinationally.
  - The head word is visible whenever `empty` is low.
  - `r_en` pops the head, and the next word appears right after the same edge.
  - When `empty` is high, `data_out` is undefined.
  - `data_out` ignores `rst_n` and is not a register.
- **Undefined:** standard registered-read mode as described in Operation and Timing.

## Test plan
- **Reset, then fill.** Apply reset, then write 0x11..0x18 on 8 consecutive cycles.
  - After each write, `fill_level` steps 1..8.
  - `almost_full` rises after the 6th write.
  - `full`=1 after the 8th write.
  - A 9th write of 0x99 sets `overflow`, and `fill_level` stays 8.
- **Drain.** From full, issue 8 reads.
  - Standard mode: `data_out` shows 0x11..0x18, each one cycle after its read.
  - `almost_empty` rises when `fill_level` reaches 2.
  - `empty`=1 after the 8th read.
  - A further read sets `underflow`.
- **Wrap-around.**
  - Write 5 words, read 3, write 6 → `full`=1 and `fill_level`=8.
  - Read all 8 → data returned in write order across the address wrap.
- **Simultaneous requests.**
  - Full with `w_en`=`r_en`=1 → `fill_level`=7 and `overflow`=1.
  - Empty with both high, writing 0xAB → `fill_level`=1, `underflow`=1; the next read returns 0xAB.
- **Flush and clear.**
  - With 4 words stored, assert `flush` together with `w_en` → `empty`=1, `fill_level`=0, and the write is dropped.
  - `clr_err` clears the sticky flags.
  - `rst_n` low mid-fill returns every output to its reset value.
- **FWFT build.** With `SYNC_FIFO_FWFT_EN` defined:
  - Write 0x5A → `data_out`=0x5A with no `r_en`.
  - Write 0x5B, then pop → `data_out`=0x5B right after the pop edge.
